// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers.
// Multi-cycle mult/div sequencing plus mthi/mtlo/mfhi/mflo.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_md_use,
  output logic [31:0] E_md_out,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        flush_q;

  logic [3:0]  op_v;
  logic        start;
  logic        is_sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [31:0] uq, ur, quo, rem;

  // The E stage holds a bubble in the first cycle after reset.
  assign op_v  = flush_q ? 4'd0 : E_md_op;
  assign start = (state_q == IDLE) &&
                 (op_v >= OP_MULT) && (op_v <= OP_DIVU);

  assign is_sgn = (op_q == OP_MULT) || (op_q == OP_DIV);

  // Sign-extended 64-bit product; low 64 bits are exact for both forms.
  always_comb begin
    mul_a = {{32{is_sgn & a_q[31]}}, a_q};
    mul_b = {{32{is_sgn & b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
  end

  // Magnitude divide with sign fix-up: quotient truncates toward zero,
  // remainder follows the dividend.
  always_comb begin
    a_neg = is_sgn & a_q[31];
    b_neg = is_sgn & b_q[31];
    abs_a = a_neg ? (32'd0 - a_q) : a_q;
    abs_b = b_neg ? (32'd0 - b_q) : b_q;
    uq    = 32'd0;
    ur    = 32'd0;
    if (abs_b != 32'd0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem = a_neg ? (32'd0 - ur) : ur;
  end

  // Next-state, operand capture and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = (op_v >= OP_DIV) ? 4'd10 : 4'd5;
          op_d    = op_v;
          a_d     = E_rs_data;
          b_d     = E_rt_data;
        end else if (op_v == OP_MTHI) begin
          hi_d = E_rs_data;
        end else if (op_v == OP_MTLO) begin
          lo_d = E_rs_data;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (op_q <= OP_MULTU) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      flush_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flush_q <= 1'b0;
    end
  end

  assign busy     = (state_q == BUSY);
  assign md_stall = D_md_use & (start | busy);
  assign HI       = hi_q;
  assign LO       = lo_q;

  // Move-from result mux.
  always_comb begin
    E_md_out = 32'd0;
    unique case (op_v)
      OP_MFHI: E_md_out = hi_q;
      OP_MFLO: E_md_out = lo_q;
      default: E_md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl.
// Vector table for arithmetic plus sequences for stall/reset/overlap.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_md_use;
  logic [31:0] E_md_out;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_run = 0;
  int n_fail = 0;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .E_md_op   (E_md_op),
    .E_rs_data (E_rs_data),
    .E_rt_data (E_rt_data),
    .D_md_use  (D_md_use),
    .E_md_out  (E_md_out),
    .busy      (busy),
    .md_stall  (md_stall),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int n);
    int cnt;
    @(negedge clk);
    E_md_op   = op;
    E_rs_data = rs;
    E_rt_data = rt;
    @(posedge clk);
    #1;
    E_md_op   = 4'd0;
    E_rs_data = 32'hDEADBEEF;
    E_rt_data = 32'h00000001;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk({nm, ".cycles"}, cnt, n);
    chk({nm, ".hi"}, HI, ehi);
    chk({nm, ".lo"}, LO, elo);
  endtask

  initial begin
    int  cnt;
    bit  any;

    vt[0] = '{"mult",     4'd1, 32'hFFFFFFFF, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vt[1] = '{"multu",    4'd2, 32'hFFFFFFFF, 32'd2,
              32'h00000001, 32'hFFFFFFFE, 5};
    vt[2] = '{"mult_pos", 4'd1, 32'h12345678, 32'h10,
              32'h00000001, 32'h23456780, 5};
    vt[3] = '{"div_neg",  4'd3, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[4] = '{"divu",     4'd4, 32'd7, 32'd2,
              32'd1, 32'd3, 10};
    vt[5] = '{"div_ovf",  4'd3, 32'h80000000, 32'hFFFFFFFF,
              32'd0, 32'h80000000, 10};
    vt[6] = '{"div_nn",   4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE,
              32'hFFFFFFFF, 32'd3, 10};
    vt[7] = '{"divu_big", 4'd4, 32'hFFFFFFFF, 32'h10,
              32'h0000000F, 32'h0FFFFFFF, 10};

    reset     = 1'b1;
    E_md_op   = 4'd1;
    E_rs_data = 32'd3;
    E_rt_data = 32'd3;
    D_md_use  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.hi", HI, 0);
    chk("rst.lo", LO, 0);
    chk("rst.stall", md_stall, 0);
    E_md_op = 4'd7;
    #1;
    chk("rst.mdout", E_md_out, 0);
    @(posedge clk);
    #1;
    chk("rst.nostart", busy, 0);
    E_md_op  = 4'd0;
    D_md_use = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vt[i].name, vt[i].op, vt[i].rs, vt[i].rt,
             vt[i].hi, vt[i].lo, vt[i].n);

    // mthi, then read both registers
    @(negedge clk);
    E_md_op   = 4'd5;
    E_rs_data = 32'h12345678;
    @(posedge clk);
    #1;
    chk("mthi.busy", busy, 0);
    E_md_op = 4'd8;
    #1;
    chk("mflo", E_md_out, 32'h0FFFFFFF);
    E_md_op = 4'd7;
    #1;
    chk("mfhi", E_md_out, 32'h12345678);
    E_md_op = 4'd0;
    #1;
    chk("mfnone", E_md_out, 0);
    run_op("divz", 4'd3, 32'd5, 32'd0,
           32'h12345678, 32'h0FFFFFFF, 10);

    // mtlo write
    @(negedge clk);
    E_md_op   = 4'd6;
    E_rs_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    E_md_op = 4'd0;
    chk("mtlo.lo", LO, 32'hCAFEF00D);
    chk("mtlo.hi", HI, 32'h12345678);

    // stall window with D_md_use high
    @(negedge clk);
    D_md_use  = 1'b1;
    E_md_op   = 4'd1;
    E_rs_data = 32'd6;
    E_rt_data = 32'd7;
    #1;
    chk("stall.start", md_stall, 1);
    @(posedge clk);
    #1;
    E_md_op = 4'd0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall.busy%0d", k), md_stall, 1);
      @(posedge clk);
      #1;
    end
    chk("stall.after", md_stall, 0);
    chk("stall.lo", LO, 32'd42);

    // same with D_md_use low: never stalls
    @(negedge clk);
    D_md_use = 1'b0;
    E_md_op  = 4'd1;
    any = 1'b0;
    #1;
    any |= md_stall;
    @(posedge clk);
    #1;
    E_md_op = 4'd0;
    for (int k = 0; k < 7; k++) begin
      any |= md_stall;
      @(posedge clk);
      #1;
    end
    chk("nostall", any, 0);

    // reset during cycle 3 of a div
    @(negedge clk);
    E_md_op   = 4'd3;
    E_rs_data = 32'd100;
    E_rt_data = 32'd7;
    @(posedge clk);
    #1;
    E_md_op = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstdiv.busy", busy, 0);
    chk("rstdiv.hi", HI, 0);
    chk("rstdiv.lo", LO, 0);
    run_op("mult_after", 4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5);

    // div issued during a mult is ignored
    @(negedge clk);
    E_md_op   = 4'd1;
    E_rs_data = 32'hFFFFFFFF;
    E_rt_data = 32'd2;
    @(posedge clk);
    #1;
    E_md_op   = 4'd3;
    E_rs_data = 32'd100;
    E_rt_data = 32'd7;
    cnt = 1;
    @(negedge clk);
    E_md_op = 4'd8;
    #1;
    chk("ovl.mflo", E_md_out, 32'd12);
    @(posedge clk);
    #1;
    E_md_op = 4'd0;
    while (busy && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("ovl.cycles", cnt, 5);
    chk("ovl.hi", HI, 32'hFFFFFFFF);
    chk("ovl.lo", LO, 32'hFFFFFFFE);
    repeat (12) @(posedge clk);
    #1;
    chk("ovl.idle", busy, 0);
    chk("ovl.lo2", LO, 32'hFFFFFFFE);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
